inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_if.sv | 11 +
 rtl/inst_fetch.sv | 153 +++++++++++++++
 tb/tb_inst_fetch.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and instruction memory.
// The fetch side holds im_req/im_addr; the memory answers with a one-cycle im_ack plus im_data.
interface inst_fetch_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_data;

  modport master (output im_req, im_addr, input im_ack, im_data);
  modport slave  (input im_req, im_addr, output im_ack, im_data);
endinterface

// File: rtl/inst_fetch.sv
// IF stage: fetches at PC into the IF/ID register with a one-entry word buffer; one instr/cycle on zero-wait memory.
// if_en=0 holds PC and IF/ID; an unavailable word with if_en=1 inserts a bubble; redirects apply after the delay slot.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_if_rst,
  input  logic        i_if_en,
  input  logic [2:0]  i_pc_src,
  input  logic [31:0] i_jump_target,
  input  logic [31:0] i_jr_target,
  input  logic [31:0] i_branch_target,
  inst_fetch_if.master im,
  output logic [31:0] o_inst_id,
  output logic [31:0] o_pc_id,
  output logic        o_if_valid
);

  typedef enum logic [1:0] {S_REQ, S_DONE, S_DROP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_drop_addr;
  logic [31:0] r_buf;
  logic        r_pend_vld;
  logic [31:0] r_pend_tgt;
  logic [31:0] r_inst_id;
  logic [31:0] r_pc_id;
  logic        r_if_valid;

  logic        w_avail;
  logic        w_handoff;
  logic        w_bubble;
  logic        w_capture;
  logic        w_redirect;
  logic        w_pend_set;
  logic [31:0] w_word;
  logic [31:0] w_tgt;
  logic [31:0] w_pc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_REQ;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_avail     = 1'b0;
    w_handoff   = 1'b0;
    w_bubble    = 1'b0;
    w_capture   = 1'b0;
    im.im_req   = (r_state != S_DONE);
    im.im_addr  = (r_state == S_DROP) ? r_drop_addr : r_pc;
    w_word      = (r_state == S_DONE) ? r_buf : im.im_data;

    w_avail = (r_state == S_DONE) || ((r_state == S_REQ) && im.im_ack);

    if (i_if_rst) begin
      // A request still in flight must be retired before a new address can be issued.
      if ((r_state != S_DONE) && !im.im_ack) w_state_nxt = S_DROP;
      else                                   w_state_nxt = S_REQ;
    end else begin
      case (r_state)
        S_REQ: begin
          if (im.im_ack) begin
            if (i_if_en) begin
              w_handoff   = 1'b1;
              w_state_nxt = S_REQ;
            end else begin
              w_capture   = 1'b1;
              w_state_nxt = S_DONE;
            end
          end else if (i_if_en) begin
            w_bubble = 1'b1;
          end
        end
        S_DONE: begin
          if (i_if_en) begin
            w_handoff   = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
        S_DROP: begin
          if (im.im_ack) w_state_nxt = S_REQ;
          if (i_if_en)   w_bubble    = 1'b1;
        end
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  always_comb begin
    w_redirect = 1'b1;
    case (i_pc_src)
      3'd1:    w_tgt = i_jump_target;
      3'd2:    w_tgt = i_jr_target;
      3'd3:    w_tgt = i_branch_target;
      default: begin
        w_tgt      = 32'h0;
        w_redirect = 1'b0;
      end
    endcase
    w_tgt[1:0] = 2'b00;

    if (r_pend_vld)      w_pc_nxt = r_pend_tgt;
    else if (w_redirect) w_pc_nxt = w_tgt;
    else                 w_pc_nxt = r_pc + 32'd4;

    // First redirect seen while stalled wins; later ones are dropped.
    w_pend_set = !i_if_rst && i_if_en && !w_avail && w_redirect && !r_pend_vld;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_drop_addr <= RESET_PC;
      r_buf       <= 32'h0;
      r_pend_vld  <= 1'b0;
      r_pend_tgt  <= 32'h0;
      r_inst_id   <= 32'h0;
      r_pc_id     <= 32'h0;
      r_if_valid  <= 1'b0;
    end else if (i_if_rst) begin
      r_pc       <= RESET_PC;
      r_pend_vld <= 1'b0;
      r_inst_id  <= 32'h0;
      r_pc_id    <= 32'h0;
      r_if_valid <= 1'b0;
      if ((r_state == S_REQ) && !im.im_ack) r_drop_addr <= r_pc;
    end else begin
      if (w_handoff) begin
        r_inst_id  <= w_word;
        r_pc_id    <= r_pc;
        r_if_valid <= 1'b1;
        r_pc       <= w_pc_nxt;
        r_pend_vld <= 1'b0;
      end
      if (w_bubble)  r_if_valid <= 1'b0;
      if (w_capture) r_buf      <= im.im_data;
      if (w_pend_set) begin
        r_pend_vld <= 1'b1;
        r_pend_tgt <= w_tgt;
      end
    end
  end

  assign o_inst_id  = r_inst_id;
  assign o_pc_id    = r_pc_id;
  assign o_if_valid = r_if_valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed-vector bench for inst_fetch; the bench plays instruction memory with per-cycle ack control.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        if_rst;
  logic        if_en;
  logic [2:0]  pc_src;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] branch_target;
  logic [31:0] inst_id;
  logic [31:0] pc_id;
  logic        if_valid;

  int n_cmp = 0;
  int n_err = 0;

  inst_fetch_if bus ();

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_if_rst        (if_rst),
    .i_if_en         (if_en),
    .i_pc_src        (pc_src),
    .i_jump_target   (jump_target),
    .i_jr_target     (jr_target),
    .i_branch_target (branch_target),
    .im              (bus),
    .o_inst_id       (inst_id),
    .o_pc_id         (pc_id),
    .o_if_valid      (if_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Memory answers only with the address it is being asked for; otherwise junk on the data bus.
  task automatic cyc(input logic ack, input logic en, input logic [2:0] src);
    if_en       = en;
    pc_src      = src;
    bus.im_ack  = ack;
    bus.im_data = (ack && bus.im_req) ? word(bus.im_addr) : 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] addr);
    check_eq({tag, ".valid"}, {31'h0, if_valid}, {31'h0, v});
    check_eq({tag, ".pc_id"}, pc_id, pc);
    check_eq({tag, ".addr"}, bus.im_addr, addr);
  endtask

  initial begin
    rst = 1'b0; if_rst = 1'b0; if_en = 1'b1; pc_src = 3'd0;
    jump_target = 32'h0; jr_target = 32'h0; branch_target = 32'h0;
    bus.im_ack = 1'b0; bus.im_data = 32'h0;
    #1 rst = 1'b1;
    #2;
    check_eq("rst.valid", {31'h0, if_valid}, 32'h0);
    check_eq("rst.inst", inst_id, 32'h0);
    check_eq("rst.pc_id", pc_id, 32'h0);
    check_eq("rst.req", {31'h0, bus.im_req}, 32'h1);
    check_eq("rst.addr", bus.im_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Zero-wait streaming
    cyc(1, 1, 0); chk_id("zw0", 1, 32'h0, 32'h4);
    check_eq("zw0.inst", inst_id, word(32'h0));
    cyc(1, 1, 0); chk_id("zw1", 1, 32'h4, 32'h8);
    cyc(1, 1, 0); chk_id("zw2", 1, 32'h8, 32'hC);
    cyc(1, 1, 0); chk_id("zw3", 1, 32'hC, 32'h10);
    check_eq("zw3.inst", inst_id, word(32'hC));

    // Stage re-init with ack present restarts at RESET_PC
    if_rst = 1'b1;
    cyc(1, 1, 0); chk_id("ifrst", 0, 32'h0, 32'h0);
    check_eq("ifrst.inst", inst_id, 32'h0);
    if_rst = 1'b0;
    cyc(1, 1, 0); chk_id("re0", 1, 32'h0, 32'h4);
    cyc(1, 1, 0); chk_id("re1", 1, 32'h4, 32'h8);

    // Jump with delay slot at 0x8
    jump_target = 32'h100;
    cyc(1, 1, 1); chk_id("jmp.slot", 1, 32'h8, 32'h100);
    cyc(1, 1, 0); chk_id("jmp.tgt", 1, 32'h100, 32'h104);

    // pc_src 5 is NEXT; JR target gets its low bits cleared
    jr_target = 32'h203; branch_target = 32'h777;
    cyc(1, 1, 5); chk_id("src5", 1, 32'h104, 32'h108);
    cyc(1, 1, 2); chk_id("jr.slot", 1, 32'h108, 32'h200);
    cyc(1, 1, 0); chk_id("jr.tgt", 1, 32'h200, 32'h204);

    // Two-cycle memory latency
    cyc(0, 1, 0); chk_id("lat0", 0, 32'h200, 32'h204);
    check_eq("lat0.req", {31'h0, bus.im_req}, 32'h1);
    cyc(1, 1, 0); chk_id("lat1", 1, 32'h204, 32'h208);
    cyc(0, 1, 0); chk_id("lat2", 0, 32'h204, 32'h208);
    cyc(1, 1, 0); chk_id("lat3", 1, 32'h208, 32'h20C);

    // Redirect while stalled: first one is held pending, second ignored
    branch_target = 32'h40; jump_target = 32'h300;
    cyc(0, 1, 3); chk_id("pend0", 0, 32'h208, 32'h20C);
    cyc(0, 1, 1); chk_id("pend1", 0, 32'h208, 32'h20C);
    cyc(1, 1, 0); chk_id("pend.slot", 1, 32'h20C, 32'h40);
    cyc(1, 1, 0); chk_id("pend.tgt", 1, 32'h40, 32'h44);
    cyc(1, 1, 0); chk_id("pend.clr", 1, 32'h44, 32'h48);

    // Stall with ack in first cycle: word buffered, memory idle
    cyc(1, 0, 0); chk_id("hold0", 1, 32'h44, 32'h48);
    check_eq("hold0.req", {31'h0, bus.im_req}, 32'h0);
    check_eq("hold0.state", {30'h0, dut.r_state}, 32'h1);
    cyc(0, 0, 0); chk_id("hold1", 1, 32'h44, 32'h48);
    cyc(1, 0, 0); chk_id("hold2", 1, 32'h44, 32'h48);
    check_eq("hold2.req", {31'h0, bus.im_req}, 32'h0);
    check_eq("hold2.inst", inst_id, word(32'h44));
    cyc(0, 1, 0); chk_id("hold.rel", 1, 32'h48, 32'h4C);
    check_eq("hold.rel.inst", inst_id, word(32'h48));
    check_eq("hold.rel.req", {31'h0, bus.im_req}, 32'h1);

    // if_rst with a request outstanding at 0x20: that word is dropped
    jump_target = 32'h20;
    cyc(1, 1, 1); chk_id("drop.jmp", 1, 32'h4C, 32'h20);
    if_rst = 1'b1;
    cyc(0, 1, 0); chk_id("drop0", 0, 32'h0, 32'h20);
    check_eq("drop0.req", {31'h0, bus.im_req}, 32'h1);
    check_eq("drop0.inst", inst_id, 32'h0);
    if_rst = 1'b0;
    cyc(0, 1, 0); chk_id("drop1", 0, 32'h0, 32'h20);
    cyc(1, 1, 0); chk_id("drop.ack", 0, 32'h0, 32'h0);
    cyc(1, 1, 0); chk_id("drop.f0", 1, 32'h0, 32'h4);
    check_eq("drop.f0.inst", inst_id, word(32'h0));
    cyc(1, 1, 0); chk_id("drop.f1", 1, 32'h4, 32'h8);

    // Asynchronous reset mid-cycle
    bus.im_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("arst.valid", {31'h0, if_valid}, 32'h0);
    check_eq("arst.pc_id", pc_id, 32'h0);
    check_eq("arst.inst", inst_id, 32'h0);
    check_eq("arst.addr", bus.im_addr, 32'h0);
    check_eq("arst.req", {31'h0, bus.im_req}, 32'h1);
    #1 rst = 1'b0;
    cyc(1, 1, 0); chk_id("arst.f0", 1, 32'h0, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
